// File: rtl/fou_pkg.sv
// Shared types and helpers for the interval type-2 fuzzifier.
// Each trapezoid is described by six coefficient words, stored at consecutive addresses.
package fou_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int F_A  = 0;
  localparam int F_B  = 1;
  localparam int F_C  = 2;
  localparam int F_D  = 3;
  localparam int F_SR = 4;
  localparam int F_SF = 5;
  localparam int WORDS_PER_TRAP = 6;

  // Clamp v to the all-ones value of a w-bit membership grade.
  function automatic logic [63:0] sat(input logic [63:0] v, input int unsigned w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/fou_tdm_trap_mu.sv
// Combinational trapezoid membership grade for one crisp input.
// The plateau test comes first, so a degenerate A >= B still yields MAX inside [B, C].
module trap_mu
  import fou_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  input  logic [2*W-1:0] sr,
  input  logic [2*W-1:0] sf,
  output logic [W-1:0]   mu
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0]   dx_r, dx_f;
  logic [3*W-1:0] rise, fall;

  // Differences are only consumed on the matching slope, where they cannot underflow.
  assign dx_r = x - a;
  assign dx_f = d - x;
  assign rise = {{(2*W){1'b0}}, dx_r} * {{W{1'b0}}, sr};
  assign fall = {{(2*W){1'b0}}, dx_f} * {{W{1'b0}}, sf};

  always_comb begin
    mu = '0;
    if (x >= b && x <= c)      mu = MAX;
    else if (x <= a || x >= d) mu = '0;
    else if (x < b)            mu = W'(sat(64'(rise >> W), W));
    else                       mu = W'(sat(64'(fall >> W), W));
  end

endmodule

// File: rtl/fou_tdm.sv
// Time-multiplexed fuzzifier: one (input, set) pair per enabled cycle,
// producing upper and lower membership grades of an interval type-2 set.
module fou_tdm
  import fou_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_IN  = 2,
  parameter int N_SET = 3
) (
  input  logic                               clk,
  input  logic                               RESET,
  input  logic                               EN_SCLK,
  input  logic                               start,
  input  logic [N_IN*W-1:0]                  in_data,
  input  logic                               cfg_we,
  input  logic [$clog2(N_IN*N_SET*12)-1:0]   cfg_addr,
  input  logic [2*W-1:0]                     cfg_data,
  output logic                               busy,
  output logic                               out_valid,
  output logic [$clog2(N_IN*N_SET)-1:0]      out_idx,
  output logic [W-1:0]                       out_up,
  output logic [W-1:0]                       out_low,
  output logic                               out_act,
  output logic                               done,
  output logic                               err
);
  localparam int N_TRAP = N_IN * N_SET;
  localparam int N_WORD = N_TRAP * 2 * WORDS_PER_TRAP;
  localparam int AW     = $clog2(N_WORD);
  localparam int IW     = $clog2(N_TRAP);

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, in_sel, set_sel;
  logic [N_IN-1:0][W-1:0]  in_lat;
  logic [2*W-1:0]          coef [N_WORD];
  logic [AW-1:0]           ub, lb;
  logic [W-1:0]            x, mu_up, mu_low;
  logic                    last, wr_ok;

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign last  = (idx == IW'(N_TRAP - 1));
  // Extra bit keeps the range check correct when N_WORD is a power of two.
  assign wr_ok = !busy && ({1'b0, cfg_addr} < (AW+1)'(N_WORD));
  assign ub    = AW'(idx) * AW'(2 * WORDS_PER_TRAP);
  assign lb    = ub + AW'(WORDS_PER_TRAP);

  always_comb begin
    x = '0;
    for (int i = 0; i < N_IN; i++)
      if (int'(in_sel) == i) x = in_lat[i];
  end

  trap_mu #(.W(W)) u_up (
    .x (x),
    .a (coef[ub + AW'(F_A)][W-1:0]),
    .b (coef[ub + AW'(F_B)][W-1:0]),
    .c (coef[ub + AW'(F_C)][W-1:0]),
    .d (coef[ub + AW'(F_D)][W-1:0]),
    .sr(coef[ub + AW'(F_SR)]),
    .sf(coef[ub + AW'(F_SF)]),
    .mu(mu_up)
  );

  trap_mu #(.W(W)) u_low (
    .x (x),
    .a (coef[lb + AW'(F_A)][W-1:0]),
    .b (coef[lb + AW'(F_B)][W-1:0]),
    .c (coef[lb + AW'(F_C)][W-1:0]),
    .d (coef[lb + AW'(F_D)][W-1:0]),
    .sr(coef[lb + AW'(F_SR)]),
    .sf(coef[lb + AW'(F_SF)]),
    .mu(mu_low)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)        state <= S_IDLE;
    else if (EN_SCLK) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_EVAL;
      S_EVAL:  if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Configuration writes ignore EN_SCLK; everything else is gated by it.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      idx       <= '0;
      in_sel    <= '0;
      set_sel   <= '0;
      in_lat    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_up    <= '0;
      out_low   <= '0;
      out_act   <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < N_WORD; i++) coef[i] <= '0;
    end else begin
      if (cfg_we) begin
        if (wr_ok) coef[cfg_addr] <= cfg_data;
        else       err <= 1'b1;
      end
      if (EN_SCLK) begin
        case (state)
          S_IDLE: begin
            out_valid <= 1'b0;
            if (start) begin
              in_lat  <= in_data;
              idx     <= '0;
              in_sel  <= '0;
              set_sel <= '0;
            end
          end
          S_EVAL: begin
            out_valid <= 1'b1;
            out_idx   <= idx;
            out_up    <= mu_up;
            out_low   <= (mu_low > mu_up) ? mu_up : mu_low;
            out_act   <= (mu_up != '0);
            if (mu_low > mu_up) err <= 1'b1;
            idx <= idx + 1'b1;
            if (int'(set_sel) == N_SET - 1) begin
              set_sel <= '0;
              in_sel  <= in_sel + 1'b1;
            end else begin
              set_sel <= set_sel + 1'b1;
            end
          end
          S_DONE:  out_valid <= 1'b0;
          default: out_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fou_tdm.sv
// Directed bench for fou_tdm with the default 2-input, 3-set configuration.
module tb_fou_tdm;
  logic        clk = 1'b0;
  logic        RESET, EN_SCLK, start, cfg_we;
  logic [15:0] in_data;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        busy, out_valid, out_act, done, err;
  logic [2:0]  out_idx;
  logic [7:0]  out_up, out_low;

  int passed = 0;
  int total  = 0;

  int          nb, done_cnt, done_beat, first_k;
  logic [7:0]  b_up [8];
  logic [7:0]  b_low[8];
  logic [2:0]  b_idx[8];
  logic        b_act[8];

  int          hold_at = -1, abort_at = -1, poke_k = -1, data_k = -1;
  bit          cfg_w_start = 1'b0;
  logic [6:0]  poke_addr;
  logic [15:0] poke_data, new_data;

  int exp_up1 [6] = '{137, 0, 0, 255, 255, 255};
  int exp_low1[6] = '{122, 0, 0, 255, 255, 255};

  always #5 clk = ~clk;

  fou_tdm dut (
    .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .start(start),
    .in_data(in_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .out_valid(out_valid), .out_idx(out_idx), .out_up(out_up),
    .out_low(out_low), .out_act(out_act), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_knobs;
    hold_at = -1; abort_at = -1; poke_k = -1; data_k = -1; cfg_w_start = 1'b0;
  endtask

  // Pulses start, then records every beat; bounded to 40 cycles.
  task automatic run_pass;
    nb = 0; done_cnt = 0; done_beat = -1; first_k = -1;
    @(negedge clk);
    start = 1'b1;
    if (cfg_w_start) cfg_we = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid && nb < 8) begin
        b_up[nb] = out_up; b_low[nb] = out_low; b_idx[nb] = out_idx; b_act[nb] = out_act;
        if (done) begin done_cnt++; done_beat = nb; end
        if (first_k < 0) first_k = k;
        nb++;
        if (nb - 1 == abort_at) begin
          RESET = 1'b1;
          #1;
          chk("abort_valid", out_valid, 0);
          chk("abort_up",    out_up,    0);
          chk("abort_low",   out_low,   0);
          chk("abort_idx",   out_idx,   0);
          chk("abort_busy",  busy,      0);
          chk("abort_done",  done,      0);
          chk("abort_err",   err,       0);
          clear_knobs();
          return;
        end
        if (nb - 1 == hold_at) begin
          EN_SCLK = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_idx",   out_idx,   hold_at);
            chk("hold_busy",  busy,      1);
          end
          EN_SCLK = 1'b1;
        end
      end
      if (k == data_k) in_data = new_data;
      if (k == poke_k) begin
        cfg_we = 1'b1; cfg_addr = poke_addr; cfg_data = poke_data; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      if (nb > 0 && !busy) break;
    end
    clear_knobs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; EN_SCLK = 1'b1; start = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; in_data = '0;
    #12;
    chk("rst_busy",  busy,      0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done",  done,      0);
    chk("rst_err",   err,       0);
    chk("rst_up",    out_up,    0);
    chk("rst_idx",   out_idx,   0);
    @(negedge clk) RESET = 1'b0;

    // idx0: UP A0 B1 C51 D114 SF1036, LOW A0 B1 C51 D107 SF1165
    wr(7'd1, 16'd1);  wr(7'd2, 16'd51);  wr(7'd3, 16'd114);  wr(7'd5, 16'd1036);
    wr(7'd7, 16'd1);  wr(7'd8, 16'd51);  wr(7'd9, 16'd107);  wr(7'd11, 16'd1165);

    in_data = {8'd0, 8'd80};
    run_pass();
    chk("p1_beats",     nb,        6);
    chk("p1_latency",   first_k,   1);
    chk("p1_done_cnt",  done_cnt,  1);
    chk("p1_done_beat", done_beat, 5);
    chk("p1_busy_end",  busy,      0);
    chk("p1_valid_end", out_valid, 0);
    chk("p1_err",       err,       0);
    chk("p1_act0",      b_act[0],  1);
    for (int i = 0; i < 6; i++) begin
      chk("p1_idx", b_idx[i], i);
      chk("p1_up",  b_up[i],  exp_up1[i]);
      chk("p1_low", b_low[i], exp_low1[i]);
    end

    in_data = {8'd0, 8'd30};
    run_pass();
    chk("p2_up",  b_up[0],  255);
    chk("p2_low", b_low[0], 255);

    in_data = {8'd0, 8'd200};
    run_pass();
    chk("p3_up",  b_up[0],  0);
    chk("p3_low", b_low[0], 0);
    chk("p3_act", b_act[0], 0);
    chk("p3_err", err,      0);

    // idx1: UP A10 B40 C50 D80 SR256; LOW B20 C25 D100, C raised to 60 with start
    wr(7'd12, 16'd10); wr(7'd13, 16'd40); wr(7'd14, 16'd50); wr(7'd15, 16'd80);
    wr(7'd16, 16'd256);
    wr(7'd19, 16'd20); wr(7'd20, 16'd25); wr(7'd21, 16'd100);
    in_data = {8'd0, 8'd30};
    cfg_addr = 7'd20; cfg_data = 16'd60; cfg_w_start = 1'b1;
    run_pass();
    chk("inv_up1",  b_up[1],  20);
    chk("inv_low1", b_low[1], 20);
    chk("inv_act1", b_act[1], 1);
    chk("inv_up0",  b_up[0],  255);
    chk("inv_err",  err,      1);

    // Reset in the middle of a pass, then a pass over cleared coefficients.
    in_data = {8'd5, 8'd80};
    abort_at = 3;
    run_pass();
    chk("abort_beats",   nb,       4);
    chk("abort_no_done", done_cnt, 0);
    @(negedge clk) RESET = 1'b0;
    @(negedge clk);
    chk("post_abort_done", done, 0);
    run_pass();
    chk("zc_beats",     nb,        6);
    chk("zc_done_beat", done_beat, 5);
    for (int i = 0; i < 6; i++) begin
      chk("zc_up",  b_up[i],  0);
      chk("zc_low", b_low[i], 0);
    end

    // Write and restart during a pass, input change mid-pass, enable hold.
    wr(7'd1, 16'd1); wr(7'd2, 16'd51); wr(7'd7, 16'd1); wr(7'd8, 16'd51);
    in_data = {8'd5, 8'd30};
    new_data = {8'd5, 8'd200}; data_k = 0;
    poke_addr = 7'd2; poke_data = 16'd10; poke_k = 2;
    hold_at = 2;
    run_pass();
    chk("busy_beats",     nb,        6);
    chk("busy_up0",       b_up[0],   255);
    chk("busy_idx3",      b_idx[3],  3);
    chk("busy_done_beat", done_beat, 5);
    chk("busy_err",       err,       1);
    repeat (4) @(negedge clk);
    chk("no_restart_busy",  busy,      0);
    chk("no_restart_valid", out_valid, 0);
    in_data = {8'd5, 8'd30};
    run_pass();
    chk("coef_kept_up0", b_up[0], 255);

    // Address range checks on a fresh error flag.
    @(negedge clk) RESET = 1'b1;
    @(negedge clk) RESET = 1'b0;
    chk("f_err_clear", err, 0);
    wr(7'd71, 16'd5);
    chk("f_last_addr", err, 0);
    wr(7'd72, 16'd5);
    chk("f_oob_addr", err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fou_tdm.md
FOU_TDM -- requirements
Module: fou_tdm

Interface
REQ-001 Parameter W, default 8: input/membership width; MAX = 2^W-1.
REQ-002 Parameter N_IN, default 2: number of crisp inputs.
REQ-003 Parameter N_SET, default 3: interval type-2 sets per input.
REQ-004 Port clk  in  1: single clock; all state on its rising edge.
REQ-005 Port RESET  in  1: asynchronous, active-high reset.
REQ-006 Port EN_SCLK  in  1: clock enable; low holds all state except configuration writes.
REQ-007 Port start  in  1: request one fuzzification pass.
REQ-008 Port in_data  in  N_IN*W: crisp inputs, input i at bits [i*W +: W].
REQ-009 Port cfg_we  in  1: configuration write strobe.
REQ-010 Port cfg_addr  in  clog2(N_IN*N_SET*12): coefficient word address.
REQ-011 Port cfg_data  in  2W: coefficient word.
REQ-012 Port busy  out  1: pass in progress.
REQ-013 Port out_valid  out  1: result beat valid.
REQ-014 Port out_idx  out  clog2(N_IN*N_SET): result index = in*N_SET+set.
REQ-015 Port out_up, out_low  out  W each: upper/lower membership.
REQ-016 Port out_act  out  1: set active (out_up != 0).
REQ-017 Port done  out  1: one-cycle end-of-pass pulse.
REQ-018 Port err  out  1: sticky fault flag.

Function
REQ-019 Coefficient map: addr = (idx*2 + ul)*6 + f; ul 0=UP, 1=LOW; f 0..5 = A,B,C,D (low W bits of cfg_data),SR,SF (full 2W bits).
REQ-020 Membership: B<=x<=C -> MAX (highest priority); else x<=A or x>=D -> 0; A<x<B -> sat(((x-A)*SR)>>W); C<x<D -> sat(((D-x)*SF)>>W); sat clamps to MAX; products 3W bits wide, no overflow.
REQ-021 FSM states IDLE, EVAL, DONE; transitions only on cycles with EN_SCLK=1.
REQ-022 IDLE: start=1 -> latch in_data, idx=0, go to EVAL; busy=1 from next cycle.
REQ-023 EVAL: each enabled cycle evaluate UP and LOW for idx, register results (out_valid=1 next cycle), idx+1; at idx = N_IN*N_SET-1 go to DONE.
REQ-024 DONE: done=1 for one cycle, concurrent with final out_valid beat; then IDLE, busy=0.
REQ-025 Latency: first beat 2 enabled cycles after start sampled; N_IN*N_SET consecutive beats; done on last beat.
REQ-026 start while busy is ignored; in_data changes during a pass do not affect it.
REQ-027 If computed LOW > UP: out_low = out_up, err set.
REQ-028 cfg_we while busy: write dropped, err set; cfg_addr out of range: write dropped, err set.
REQ-029 cfg_we and start in the same IDLE cycle: write lands first; pass uses new value.
REQ-030 EN_SCLK=0 mid-pass: state, idx, outputs held; out_valid held but counts as no new beat.
REQ-031 err clears only on RESET.

Reset
REQ-032 RESET asserted: FSM IDLE, idx 0, all outputs 0, err 0, all coefficients 0, latched inputs 0; takes effect immediately, aborting any pass without done.

Structure
REQ-033 Package fou_pkg: state enum, field offsets A..SF, words-per-trapezoid 6, sat helper.
REQ-034 One sub-module trap_mu (combinational, one trapezoid per instance), instantiated twice (UP, LOW).

Verification
REQ-035 Set idx0 UP A0 B1 C51 D114 SF1036, LOW A0 B1 C51 D107 SF1165, input0=80, start -> beat idx0 up=137 low=122 act=1.
REQ-036 Same config, input0=30 -> up=255 low=255; input0=200 -> up=0 low=0 act=0.
REQ-037 N_IN=2,N_SET=3, start -> 6 beats idx 0..5 on consecutive cycles, done with idx5, busy low after.
REQ-038 LOW plateau B20 C60 wider than UP plateau B40 C50, x=30 -> out_low=out_up, err=1.
REQ-039 cfg_we during pass -> coefficient unchanged, err=1; start during pass -> no second pass.
REQ-040 RESET asserted at beat 3 -> outputs 0 at once, no done, next start gives full 6-beat pass with zero coefficients.
